gemm_cmd_encoder: RTL and testbench

Host-side command encoder for the GEMM master controller. Accepts one typed command per handshake: opcode plus a payload of up to three 32-bit words. Assigns a sequential command ID, computes the header length field, and serializes header + payload into the 32-bit word stream that feeds the master controller command FIFO. It is the transmit end of the command-word protocol that the controller decodes.

---
 rtl/gemm_cmd_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_gemm_cmd_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gemm_cmd_encoder.sv
// gemm_cmd_encoder
// Serializes one typed GEMM command (opcode + up to three payload words) into
// the 32-bit command-word stream consumed by the master controller FIFO.
// Each accepted command is emitted as a header word {8'h00, len, id, op}
// followed by len/4 payload words, Word1 first.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   v_i / ready_o       command handshake (ready only while idle)
//   op_i, payload_i     opcode and payload ([31:0] = Word1 ... [95:64] = Word3)
//   id_o                ID assigned to the command accepted this cycle
//   data_o, v_o, last_o registered output word stream
//   ready_i             downstream FIFO ready
//   err_o, err_clr_i    sticky unknown-opcode flag and its clear
//   cmds_sent_o         commands fully emitted (saturating)
//   words_sent_o        words emitted (saturating)
//
// Configuration macro: GEMM_CMD_ENC_STATS_EN enables the statistics counters;
// when undefined both stats ports read 0 and no counter flops are built.
// id_width_p must be 8 to fit the header ID field.

module gemm_cmd_encoder #(
    parameter int id_start_p = 0,
    parameter int id_width_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic [7:0]            op_i,
    input  logic [95:0]           payload_i,
    output logic [id_width_p-1:0] id_o,
    output logic [31:0]           data_o,
    output logic                  v_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic [15:0]           cmds_sent_o,
    output logic [15:0]           words_sent_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [id_width_p-1:0]   id_q;
    logic [7:0]              len_q;
    logic [95:0]             payload_q;
    logic [1:0]              idx_q;
    logic [31:0]             data_q;
    logic                    v_q;
    logic                    last_q;
    logic                    err_q;

    logic                    op_known_d;
    logic [7:0]              len_d;
    logic                    err_d;
    logic                    accept;
    logic [1:0]              last_idx;

    // Select payload word idx (0 = Word1).
    function automatic logic [31:0] pay_word(input logic [95:0] p, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = p[31:0];
            2'd1:    w = p[63:32];
            2'd2:    w = p[95:64];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign accept  = v_i & ready_o;
    assign ready_o = (state_q == ST_IDLE);
    assign id_o    = id_q;
    assign data_o  = data_q;
    assign v_o     = v_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

    // Only the 12-byte ops carry three payload words; everything else has one.
    assign last_idx = (len_q == 8'd12) ? 2'd2 : 2'd0;

    // Opcode decode: known flag and header length in bytes.
    always_comb begin
        op_known_d = 1'b0;
        len_d      = 8'd0;
        case (op_i)
            8'hF0, 8'hF1, 8'hF2: begin
                op_known_d = 1'b1;
                len_d      = 8'd12;
            end
            8'hF3, 8'hF4: begin
                op_known_d = 1'b1;
                len_d      = 8'd4;
            end
            default: begin
                op_known_d = 1'b0;
                len_d      = 8'd0;
            end
        endcase
    end

    // Sticky error next state; a new unknown opcode outranks a clear.
    always_comb begin
        err_d = err_q;
        if (accept && !op_known_d) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Command FSM with registered output word, valid and last.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            id_q      <= id_width_p'(id_start_p);
            len_q     <= 8'd0;
            payload_q <= 96'd0;
            idx_q     <= 2'd0;
            data_q    <= 32'd0;
            v_q       <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    // Unknown opcodes are consumed here without emitting words.
                    if (accept && op_known_d) begin
                        len_q     <= len_d;
                        payload_q <= payload_i;
                        id_q      <= id_q + 1'b1;
                        data_q    <= {8'h00, len_d, id_q, op_i};
                        v_q       <= 1'b1;
                        last_q    <= 1'b0;
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (ready_i) begin
                        idx_q   <= 2'd0;
                        data_q  <= pay_word(payload_q, 2'd0);
                        last_q  <= (last_idx == 2'd0);
                        state_q <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (ready_i) begin
                        if (last_q) begin
                            data_q  <= 32'd0;
                            v_q     <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q  <= idx_q + 2'd1;
                            data_q <= pay_word(payload_q, idx_q + 2'd1);
                            last_q <= ((idx_q + 2'd1) == last_idx);
                        end
                    end
                end
                default: begin
                    data_q  <= 32'd0;
                    v_q     <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GEMM_CMD_ENC_STATS_EN
    logic [15:0] cmds_q;
    logic [15:0] words_q;

    // Saturating word/command counters, stepped on output handshakes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmds_q  <= 16'd0;
            words_q <= 16'd0;
        end else if (v_q && ready_i) begin
            if (words_q != 16'hFFFF) begin
                words_q <= words_q + 16'd1;
            end
            if (last_q && (cmds_q != 16'hFFFF)) begin
                cmds_q <= cmds_q + 16'd1;
            end
        end
    end

    assign cmds_sent_o  = cmds_q;
    assign words_sent_o = words_q;
`else
    assign cmds_sent_o  = 16'd0;
    assign words_sent_o = 16'd0;
`endif

endmodule

// File: tb/tb_gemm_cmd_encoder.sv
// Directed testbench for gemm_cmd_encoder: fetch, tile with backpressure,
// wait ops, unknown opcode / sticky error, ID wrap, and reset mid-command.

module tb_gemm_cmd_encoder;

`ifdef GEMM_CMD_ENC_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [7:0]  op_i;
    logic [95:0] payload_i;
    logic [7:0]  id_o;
    logic [31:0] data_o;
    logic        v_o;
    logic        ready_i;
    logic        last_o;
    logic        err_o;
    logic        err_clr_i;
    logic [15:0] cmds_sent_o;
    logic [15:0] words_sent_o;

    int n_checks = 0;
    int n_errors = 0;

    gemm_cmd_encoder #(.id_start_p(0), .id_width_p(8)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .payload_i    (payload_i),
        .id_o         (id_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i),
        .cmds_sent_o  (cmds_sent_o),
        .words_sent_o (words_sent_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Check the current output word, then let it hand off (ready_i assumed high).
    task automatic exp_word(input string tag, input logic [31:0] d, input logic l);
        check_eq({tag, "_v"}, {31'd0, v_o}, 32'd1);
        check_eq({tag, "_data"}, data_o, d);
        check_eq({tag, "_last"}, {31'd0, last_o}, {31'd0, l});
        tick();
    endtask

    initial begin
        reset_i   = 1'b1;
        v_i       = 1'b0;
        op_i      = 8'h00;
        payload_i = 96'd0;
        ready_i   = 1'b1;
        err_clr_i = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
        check_eq("rst_v", {31'd0, v_o}, 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_last", {31'd0, last_o}, 32'd0);
        check_eq("rst_err", {31'd0, err_o}, 32'd0);
        check_eq("rst_id", {24'd0, id_o}, 32'd0);
        check_eq("rst_words", {16'd0, words_sent_o}, 32'd0);
        check_eq("rst_cmds", {16'd0, cmds_sent_o}, 32'd0);
        reset_i = 1'b0;
        tick();

        // Fetch, ready_i held high
        v_i = 1'b1; op_i = 8'hF0;
        payload_i = {32'h0000_0001, 32'h0000_0040, 32'h2000_0000};
        check_eq("f_ready", {31'd0, ready_o}, 32'd1);
        check_eq("f_id", {24'd0, id_o}, 32'd0);
        tick();
        v_i = 1'b0;
        exp_word("f_hdr", 32'h000C_00F0, 1'b0);
        exp_word("f_w1", 32'h2000_0000, 1'b0);
        exp_word("f_w2", 32'h0000_0040, 1'b0);
        exp_word("f_w3", 32'h0000_0001, 1'b1);
        check_eq("f_done_v", {31'd0, v_o}, 32'd0);
        check_eq("f_done_ready", {31'd0, ready_o}, 32'd1);
        check_eq("f_words", {16'd0, words_sent_o}, STATS_EN ? 32'd4 : 32'd0);
        check_eq("f_cmds", {16'd0, cmds_sent_o}, STATS_EN ? 32'd1 : 32'd0);

        // Tile with backpressure during Word2
        v_i = 1'b1; op_i = 8'hF2;
        payload_i = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        check_eq("t_id", {24'd0, id_o}, 32'd1);
        tick();
        v_i = 1'b0;
        exp_word("t_hdr", 32'h000C_01F2, 1'b0);
        exp_word("t_w1", 32'hAAAA_0001, 1'b0);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t_bp_v", {31'd0, v_o}, 32'd1);
            check_eq("t_bp_data", data_o, 32'hBBBB_0002);
            check_eq("t_bp_last", {31'd0, last_o}, 32'd0);
            check_eq("t_bp_ready", {31'd0, ready_o}, 32'd0);
            tick();
        end
        ready_i = 1'b1;
        exp_word("t_w2", 32'hBBBB_0002, 1'b0);
        check_eq("t_busy", {31'd0, ready_o}, 32'd0);
        exp_word("t_w3", 32'hCCCC_0003, 1'b1);
        check_eq("t_done_ready", {31'd0, ready_o}, 32'd1);
        check_eq("t_done_v", {31'd0, v_o}, 32'd0);

        // wait_tile
        v_i = 1'b1; op_i = 8'hF4; payload_i = {64'd0, 32'h0000_0005};
        check_eq("wt_id", {24'd0, id_o}, 32'd2);
        tick();
        v_i = 1'b0;
        exp_word("wt_hdr", 32'h0004_02F4, 1'b0);
        exp_word("wt_w1", 32'h0000_0005, 1'b1);
        check_eq("wt_done_v", {31'd0, v_o}, 32'd0);

        // Unknown opcode
        v_i = 1'b1; op_i = 8'h7A; payload_i = 96'd0;
        tick();
        v_i = 1'b0;
        check_eq("u_v", {31'd0, v_o}, 32'd0);
        check_eq("u_err", {31'd0, err_o}, 32'd1);
        check_eq("u_ready", {31'd0, ready_o}, 32'd1);
        v_i = 1'b1; op_i = 8'hF3; payload_i = {64'd0, 32'h0000_0009};
        check_eq("u_next_id", {24'd0, id_o}, 32'd3);
        tick();
        v_i = 1'b0;
        exp_word("u_hdr", 32'h0004_03F3, 1'b0);
        exp_word("u_w1", 32'h0000_0009, 1'b1);
        check_eq("u_err_held", {31'd0, err_o}, 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check_eq("u_err_clr", {31'd0, err_o}, 32'd0);
        // Set and clear in the same cycle: set wins
        v_i = 1'b1; op_i = 8'h00; err_clr_i = 1'b1;
        tick();
        v_i = 1'b0; err_clr_i = 1'b0;
        check_eq("u_set_wins", {31'd0, err_o}, 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check_eq("u_err_clr2", {31'd0, err_o}, 32'd0);

        // ID wrap over 257 wait_disp commands from a fresh reset
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 257; i++) begin
            v_i = 1'b1; op_i = 8'hF3; payload_i = 96'(i);
            check_eq("wrap_id", {24'd0, id_o}, 32'(i % 256));
            tick();
            v_i = 1'b0;
            tick();
            tick();
        end
        check_eq("wrap_after", {24'd0, id_o}, 32'd1);
        check_eq("wrap_words", {16'd0, words_sent_o}, STATS_EN ? 32'd514 : 32'd0);
        check_eq("wrap_cmds", {16'd0, cmds_sent_o}, STATS_EN ? 32'd257 : 32'd0);

        // Reset mid-PAY after Word1
        v_i = 1'b1; op_i = 8'hF0;
        payload_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        check_eq("r_id", {24'd0, id_o}, 32'd1);
        tick();
        v_i = 1'b0;
        exp_word("r_hdr", 32'h000C_01F0, 1'b0);
        exp_word("r_w1", 32'h1111_1111, 1'b0);
        check_eq("r_pre_v", {31'd0, v_o}, 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("r_v", {31'd0, v_o}, 32'd0);
        check_eq("r_ready", {31'd0, ready_o}, 32'd1);
        check_eq("r_data", data_o, 32'd0);
        check_eq("r_id_start", {24'd0, id_o}, 32'd0);
        check_eq("r_words", {16'd0, words_sent_o}, 32'd0);
        check_eq("r_cmds", {16'd0, cmds_sent_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        check_eq("r_idle_v", {31'd0, v_o}, 32'd0);
        v_i = 1'b1; op_i = 8'hF4; payload_i = 96'd0;
        check_eq("r_next_id", {24'd0, id_o}, 32'd0);
        tick();
        v_i = 1'b0;
        exp_word("r_next_hdr", 32'h0004_00F4, 1'b0);
        exp_word("r_next_w1", 32'h0000_0000, 1'b1);
        check_eq("r_next_done", {31'd0, ready_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
